// File: rtl/img_mem_pkg.sv
// img_mem_pkg: shared definitions for the image-memory write path.
//   img_wr_state_t : writer FSM state encoding
//   IMG_DEPTH      : pixels per 28x28 frame
//   PIX_W          : pixel width
//   params_ok()    : legality check for the bank count and gap length
package img_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } img_wr_state_t;

  localparam int IMG_DEPTH = 784;
  localparam int PIX_W     = 8;
  localparam int MAX_BANKS = 8;
  localparam int MAX_GAP   = 15;

  function automatic bit params_ok(input int banks, input int gap);
    return (banks >= 1) && (banks <= MAX_BANKS) && (gap >= 0) && (gap <= MAX_GAP);
  endfunction

endpackage

// File: rtl/img_mem_writer_bank_addr_gen.sv
// bank_addr_gen: bank-interleave address generator.
// Walks pixel index p as (bank = p mod BANKS, row = p div BANKS) using a
// wrapping bank counter that carries into the row counter.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   clr            : synchronous clear of bank and row counters
//   adv            : advance to the next pixel position
//   row            : current row address (shared by all banks)
//   bank_onehot    : one-hot decode of the current bank index
module bank_addr_gen
  import img_mem_pkg::*;
#(
  parameter int BANKS  = 1,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] row,
  output logic [BANKS-1:0]  bank_onehot
);

  localparam int BIDX_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [BIDX_W-1:0] BANK_LAST = BIDX_W'(BANKS - 1);

  logic [BIDX_W-1:0] bank_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_idx <= '0;
      row      <= '0;
    end else if (clr) begin
      bank_idx <= '0;
      row      <= '0;
    end else if (adv) begin
      if (bank_idx == BANK_LAST) begin
        bank_idx <= '0;
        row      <= row + ADDR_W'(1);
      end else begin
        bank_idx <= bank_idx + BIDX_W'(1);
      end
    end
  end

  always_comb begin
    bank_onehot = '0;
    for (int i = 0; i < BANKS; i++) begin
      bank_onehot[i] = (bank_idx == BIDX_W'(i));
    end
  end

endmodule

// File: rtl/img_mem_writer.sv
// img_mem_writer: write-side addresser for the input-image memory.
// Accepts one pixel per valid/ready beat and writes it into one of BANKS
// image banks (bank-interleaved), optionally idling GAP cycles after each
// pixel, and raises done after DEPTH pixels.
// Ports:
//   clk, reset_n         : clock, async active-low reset
//   start                : begin a frame (honoured in IDLE or DONE)
//   abort                : return to IDLE, highest priority
//   in_valid, in_data    : pixel beat from the bus slave
//   in_ready             : combinational ready, high only in WRITE without abort
//   mem_we               : registered one-hot bank write enable
//   mem_addr, mem_wdata  : registered row address and write data
//   count                : pixels accepted in the current frame
//   busy                 : registered, high in WRITE or GAP
//   done                 : registered level, high in DONE
//
// state  | meaning
// IDLE   | waiting for start
// WRITE  | ready for a pixel
// GAP    | enforced idle after a pixel, in_ready low
// DONE   | DEPTH pixels written, waiting for start
module img_mem_writer
  import img_mem_pkg::*;
#(
  parameter  int DEPTH      = IMG_DEPTH,
  parameter  int DATA_W     = PIX_W,
  parameter  int BANKS      = 1,
  parameter  int GAP        = 0,
  localparam int BANK_DEPTH = (DEPTH + BANKS - 1) / BANKS,
  localparam int ADDR_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [BANKS-1:0]  mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done
);

  if (!params_ok(BANKS, GAP)) begin : g_param_err
    $error("img_mem_writer: BANKS must be 1..8 and GAP must be 0..15");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  img_wr_state_t     state, state_next;
  logic [3:0]        gap_cnt;
  logic              accept;
  logic              last;
  logic              clr;
  logic              gap_load;
  logic [ADDR_W-1:0] row;
  logic [BANKS-1:0]  bank_onehot;

  // The row/bank counters are not advanced on the final pixel so they never
  // step past the last valid position of the frame.
  bank_addr_gen #(
    .BANKS  (BANKS),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (clr),
    .adv         (accept && !last),
    .row         (row),
    .bank_onehot (bank_onehot)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clr        = 1'b0;
    gap_load   = 1'b0;
    in_ready   = (state == ST_WRITE) && !abort;
    accept     = in_ready && in_valid;
    last       = accept && (count == LAST_CNT);

    if (abort) begin
      state_next = ST_IDLE;
      clr        = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_next = ST_WRITE;
            clr        = 1'b1;
          end
        end
        ST_WRITE: begin
          if (accept) begin
            if (last) begin
              state_next = ST_DONE;
            end else if (GAP > 0) begin
              state_next = ST_GAP;
              gap_load   = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state_next = ST_WRITE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // busy/done follow the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt   <= '0;
      count     <= '0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy   <= (state_next == ST_WRITE) || (state_next == ST_GAP);
      done   <= (state_next == ST_DONE);
      mem_we <= accept ? bank_onehot : '0;
      if (accept) begin
        mem_addr  <= row;
        mem_wdata <= in_data;
      end
      if (clr) begin
        count <= '0;
      end else if (accept) begin
        count <= count + CNT_W'(1);
      end
      if (gap_load) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == ST_GAP) && (gap_cnt != 4'd0)) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_img_mem_writer.sv
// Bench for img_mem_writer: three instances (BANKS/GAP = 1/0, 4/2, 3/0),
// driven one at a time; expected writes are queued at accept time and a
// separate monitor pops and compares whenever an instance asserts mem_we.
module tb_img_mem_writer;
  import img_mem_pkg::*;

  localparam int NB       [3] = '{1, 4, 3};
  localparam int NG       [3] = '{0, 2, 0};
  localparam int EXP_B0   [3] = '{784, 196, 262};
  localparam int EXP_BL   [3] = '{784, 196, 261};
  localparam int LAST_WE  [3] = '{1, 8, 1};
  localparam int LAST_ROW [3] = '{783, 195, 261};
  localparam int P5_WE    [3] = '{1, 2, 4};
  localparam int P5_ROW   [3] = '{5, 1, 1};

  typedef struct packed {
    logic [7:0] we;
    logic [9:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n, start, abort, valid;
  logic [7:0] din;
  logic [2:0] rdy, busy, done;
  logic [7:0] wd   [3];
  logic [9:0] cnt  [3];
  logic [0:0] we0;
  logic [3:0] we1;
  logic [2:0] we2;
  logic [9:0] ad0;
  logic [7:0] ad1;
  logic [8:0] ad2;
  logic [7:0] we_a [3];
  logic [9:0] ad_a [3];

  assign we_a[0] = {7'b0, we0};
  assign we_a[1] = {4'b0, we1};
  assign we_a[2] = {5'b0, we2};
  assign ad_a[0] = ad0;
  assign ad_a[1] = {2'b0, ad1};
  assign ad_a[2] = {1'b0, ad2};

  img_mem_writer #(.DEPTH(784), .DATA_W(8), .BANKS(1), .GAP(0)) u_b1 (
    .clk(clk), .reset_n(rst_n[0]), .start(start[0]), .abort(abort[0]),
    .in_valid(valid[0]), .in_data(din), .in_ready(rdy[0]), .mem_we(we0),
    .mem_addr(ad0), .mem_wdata(wd[0]), .count(cnt[0]), .busy(busy[0]), .done(done[0]));

  img_mem_writer #(.DEPTH(784), .DATA_W(8), .BANKS(4), .GAP(2)) u_b4 (
    .clk(clk), .reset_n(rst_n[1]), .start(start[1]), .abort(abort[1]),
    .in_valid(valid[1]), .in_data(din), .in_ready(rdy[1]), .mem_we(we1),
    .mem_addr(ad1), .mem_wdata(wd[1]), .count(cnt[1]), .busy(busy[1]), .done(done[1]));

  img_mem_writer #(.DEPTH(784), .DATA_W(8), .BANKS(3), .GAP(0)) u_b3 (
    .clk(clk), .reset_n(rst_n[2]), .start(start[2]), .abort(abort[2]),
    .in_valid(valid[2]), .in_data(din), .in_ready(rdy[2]), .mem_we(we2),
    .mem_addr(ad2), .mem_wdata(wd[2]), .count(cnt[2]), .busy(busy[2]), .done(done[2]));

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  exp_t       q [3][$];
  int         pix [3];
  int         frame_no = 0;
  int         wr_cnt [3];
  int         bank_cnt [3][8];
  logic [7:0] last_we [3];
  int         last_addr [3];
  logic [7:0] p5_we [3];
  int         p5_addr [3];

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [7:0] pix_data(input int k, input int p);
    return 8'((p * 13 + k * 29 + frame_no * 71) & 255);
  endfunction

  // Monitor: every write an instance presents must match the head of its queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (we_a[k] != 8'd0) begin
          checks++;
          if (q[k].size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected[%0d]: got we=%b addr=%0d, no write expected",
                     k, we_a[k], ad_a[k]);
          end else begin
            e = q[k].pop_front();
            if (e.we != we_a[k] || e.addr != ad_a[k] || e.data != wd[k]) begin
              errors++;
              $display("FAIL wr[%0d] #%0d: got we=%b addr=%0d data=%0d expected we=%b addr=%0d data=%0d",
                       k, wr_cnt[k], we_a[k], ad_a[k], wd[k], e.we, e.addr, e.data);
            end
          end
          for (int b = 0; b < 8; b++) if (we_a[k][b]) bank_cnt[k][b]++;
          if (wr_cnt[k] == 5) begin
            p5_we[k]   = we_a[k];
            p5_addr[k] = ad_a[k];
          end
          last_we[k]   = we_a[k];
          last_addr[k] = ad_a[k];
          wr_cnt[k]++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic start_frame(input int k);
    frame_no++;
    pix[k]    = 0;
    wr_cnt[k] = 0;
    for (int b = 0; b < 8; b++) bank_cnt[k][b] = 0;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk("ready_after_start", rdy[k], 1);
    chk("count_after_start", cnt[k], 0);
    chk("busy_after_start", busy[k], 1);
    chk("done_after_start", done[k], 0);
  endtask

  task automatic run_beats(input int k, input int target, input bit rnd,
                           output int cyc, output int bad);
    bit   v;
    exp_t e;
    cyc = 0;
    bad = 0;
    while (pix[k] < target && cyc < 10000) begin
      v        = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      valid[k] = v;
      din      = pix_data(k, pix[k]);
      start[k] = !rnd && (pix[k] == 50);
      @(negedge clk);
      if (!rnd && (rdy[k] != ((cyc % (NG[k] + 1)) == 0))) bad++;
      if (v && rdy[k]) begin
        e.we   = 8'd1 << (pix[k] % NB[k]);
        e.addr = 10'(pix[k] / NB[k]);
        e.data = din;
        q[k].push_back(e);
        pix[k]++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    valid[k] = 1'b0;
    start[k] = 1'b0;
    chk("beats_reached", pix[k], target);
  endtask

  task automatic full_frame(input int k);
    int cyc, bad;
    start_frame(k);
    run_beats(k, 784, 1'b0, cyc, bad);
    chk("ready_pattern", bad, 0);
    // one accept every GAP+1 cycles; no gap follows the final pixel
    chk("frame_cycles", cyc, 784 * (NG[k] + 1) - NG[k]);
    chk("done_rise", done[k], 1);
    chk("busy_fall", busy[k], 0);
    chk("count_final", cnt[k], 784);
    chk("ready_in_done", rdy[k], 0);
    repeat (2) @(posedge clk);
    #1;
    chk("write_total", wr_cnt[k], 784);
    chk("bank0_writes", bank_cnt[k][0], EXP_B0[k]);
    chk("banklast_writes", bank_cnt[k][NB[k]-1], EXP_BL[k]);
    chk("last_we", last_we[k], LAST_WE[k]);
    chk("last_row", last_addr[k], LAST_ROW[k]);
    chk("pix5_we", p5_we[k], P5_WE[k]);
    chk("pix5_row", p5_addr[k], P5_ROW[k]);
    chk("done_held", done[k], 1);
    chk("queue_drained", q[k].size(), 0);
  endtask

  initial begin
    int cyc, bad;
    rst_n = '0; start = '0; abort = '0; valid = '0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_we", we_a[k], 0);
      chk("reset_addr", ad_a[k], 0);
      chk("reset_wdata", wd[k], 0);
      chk("reset_count", cnt[k], 0);
      chk("reset_busy_done", {busy[k], done[k]}, 0);
      chk("reset_ready", rdy[k], 0);
    end
    rst_n = '1;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) full_frame(k);

    // abort with a beat present at count 100
    start_frame(2);
    run_beats(2, 100, 1'b0, cyc, bad);
    abort[2] = 1'b1;
    valid[2] = 1'b1;
    din      = pix_data(2, pix[2]);
    #1;
    chk("ready_in_abort", rdy[2], 0);
    @(posedge clk); #1;
    abort[2] = 1'b0;
    valid[2] = 1'b0;
    chk("abort_count", cnt[2], 0);
    chk("abort_busy", busy[2], 0);
    chk("abort_done", done[2], 0);
    chk("abort_no_write", we_a[2], 0);
    chk("abort_ready", rdy[2], 0);

    // async reset mid-frame at count 300
    start_frame(2);
    run_beats(2, 300, 1'b0, cyc, bad);
    repeat (2) @(posedge clk);
    #3;
    chk("pre_reset_count", cnt[2], 300);
    rst_n[2] = 1'b0;
    #1;
    chk("async_rst_count", cnt[2], 0);
    chk("async_rst_busy", busy[2], 0);
    chk("async_rst_addr", ad_a[2], 0);
    chk("async_rst_wdata", wd[2], 0);
    chk("async_rst_we_done", {we_a[2], done[2]}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    chk("rst_queue_empty", q[2].size(), 0);
    @(posedge clk); #1;

    // new frame under random backpressure
    start_frame(2);
    run_beats(2, 784, 1'b1, cyc, bad);
    chk("bp_done", done[2], 1);
    chk("bp_count", cnt[2], 784);
    bad = 0;
    valid[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done[2] != 1'b1 || rdy[2] != 1'b0) bad++;
      @(posedge clk); #1;
    end
    valid[2] = 1'b0;
    chk("done_hold", bad, 0);
    chk("bp_write_total", wr_cnt[2], 784);
    chk("bp_bank0_writes", bank_cnt[2][0], 262);
    chk("bp_bank1_writes", bank_cnt[2][1], 261);
    start_frame(2);
    abort[2] = 1'b1;
    @(posedge clk); #1;
    abort[2] = 1'b0;
    chk("final_idle_busy", busy[2], 0);

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("end_queue_empty", q[k].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
